// File: rtl/sys_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb_pkg
// Desc   : Shared constants, state encoding and defaults for sys_bus_arb.
// Rev    : 1.0  initial release
// ============================================================================
package sys_bus_arb_pkg;

    localparam int S_IDLE = 0;
    localparam int S_ADDR = 1;
    localparam int S_XFER = 2;
    localparam int S_DONE = 3;

    localparam int DEF_N_MASTERS = 4;
    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 32;
    localparam int DEF_TIMEOUT   = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001 << S_IDLE,
        ST_ADDR = 4'b0001 << S_ADDR,
        ST_XFER = 4'b0001 << S_XFER,
        ST_DONE = 4'b0001 << S_DONE
    } state_t;

    // A disabled timeout still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb_if
// Desc   : Requester-side and slave-side bus signals of sys_bus_arb.
// Rev    : 1.0  initial release
// ============================================================================
interface sys_bus_arb_if #(
    parameter int N_MASTERS = 4,
    parameter int AW        = 8,
    parameter int DW        = 32
);
    logic [N_MASTERS-1:0]    m_req;
    logic [N_MASTERS-1:0]    m_we;
    logic [N_MASTERS*AW-1:0] m_addr;
    logic [N_MASTERS*DW-1:0] m_wdata;
    logic [N_MASTERS-1:0]    m_gnt;
    logic [N_MASTERS-1:0]    m_done;
    logic                    m_err;
    logic [DW-1:0]           m_rdata;
    logic                    bus_ready;
    logic [AW-1:0]           s_addr;
    logic                    s_we;
    logic                    s_re;
    logic [DW-1:0]           s_wdata;
    logic [DW-1:0]           s_rdata;
    logic                    s_ready;

    // Controller view.
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        output m_gnt, m_done, m_err, m_rdata, bus_ready,
               s_addr, s_we, s_re, s_wdata
    );

    // Requesters plus memory/I-O view.
    modport master (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        input  m_gnt, m_done, m_err, m_rdata, bus_ready,
               s_addr, s_we, s_re, s_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sys_bus_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb_rr_arbiter
// Desc   : Round-robin arbiter with rotating priority pointer.
// Rev    : 1.0  initial release
// ============================================================================
module sys_bus_arb_rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 en,
    input  wire logic [N-1:0]         req,
    output logic      [N-1:0]         gnt,
    output logic      [$clog2(N)-1:0] idx,
    output logic                      valid
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    // Scan from the pointer upward, wrapping modulo N.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!valid && req[w_pos]) begin
                valid      = 1'b1;
                gnt[w_pos] = 1'b1;
                idx        = w_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && valid) begin
            r_ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_bus_arb.sv
`default_nettype none
// ============================================================================
// Module : sys_bus_arb
// Desc   : Multi-master bus controller: round-robin arbitration, wait states
//          and per-transfer timeout onto a single slave port.
// Rev    : 1.0  initial release
// ============================================================================
module sys_bus_arb
    import sys_bus_arb_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input wire logic      clk,
    input wire logic      rst,
    sys_bus_arb_if.slave  bus
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int CW = cnt_width(TIMEOUT);

    state_t                 r_state;
    state_t                 w_next;

    logic [N_MASTERS-1:0]   w_arb_gnt;
    logic [IW-1:0]          w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_idle;
    logic                   w_timeout;

    logic [AW-1:0]          w_addr_arr  [N_MASTERS];
    logic [DW-1:0]          w_wdata_arr [N_MASTERS];

    logic [N_MASTERS-1:0]   r_sel_oh;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [DW-1:0]          r_wdata;
    logic [CW-1:0]          r_cnt;

    logic [N_MASTERS-1:0]   r_gnt;
    logic [N_MASTERS-1:0]   r_done;
    logic                   r_err;
    logic [DW-1:0]          r_rdata;
    logic                   r_bus_ready;
    logic                   r_s_we;
    logic                   r_s_re;
    logic [DW-1:0]          r_s_wdata;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign w_addr_arr[i]  = bus.m_addr[i*AW +: AW];
        assign w_wdata_arr[i] = bus.m_wdata[i*DW +: DW];
    end

    assign w_idle    = r_state[S_IDLE];
    // Fires on the edge that would complete the TIMEOUT-th waiting cycle.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    sys_bus_arb_rr_arbiter #(
        .N     (N_MASTERS)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (w_idle),
        .req   (bus.m_req),
        .gnt   (w_arb_gnt),
        .idx   (w_arb_idx),
        .valid (w_arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_arb_valid) w_next = ST_ADDR;
            ST_ADDR: w_next = ST_XFER;
            ST_XFER: if (bus.s_ready || w_timeout) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_oh    <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_bus_ready <= 1'b1;
            r_s_we      <= 1'b0;
            r_s_re      <= 1'b0;
            r_s_wdata   <= '0;
        end else begin
            r_bus_ready <= (w_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    r_err  <= 1'b0;
                    if (w_arb_valid) begin
                        r_sel_oh <= w_arb_gnt;
                        r_gnt    <= w_arb_gnt;
                        r_we     <= bus.m_we[w_arb_idx];
                        r_addr   <= w_addr_arr[w_arb_idx];
                        r_wdata  <= w_wdata_arr[w_arb_idx];
                    end
                end
                ST_ADDR: begin
                    r_gnt     <= '0;
                    r_cnt     <= '0;
                    r_s_we    <= r_we;
                    r_s_re    <= ~r_we;
                    r_s_wdata <= r_wdata;
                end
                ST_XFER: begin
                    // A ready slave beats a simultaneous timeout.
                    if (bus.s_ready) begin
                        if (!r_we) begin
                            r_rdata <= bus.s_rdata;
                        end
                        r_s_we <= 1'b0;
                        r_s_re <= 1'b0;
                        r_done <= r_sel_oh;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_s_we <= 1'b0;
                        r_s_re <= 1'b0;
                        r_done <= r_sel_oh;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= '0;
                    r_err  <= 1'b0;
                end
                default: begin
                    r_done <= '0;
                end
            endcase
        end
    end

    assign bus.m_gnt     = r_gnt;
    assign bus.m_done    = r_done;
    assign bus.m_err     = r_err;
    assign bus.m_rdata   = r_rdata;
    assign bus.bus_ready = r_bus_ready;
    assign bus.s_addr    = r_addr;
    assign bus.s_we      = r_s_we;
    assign bus.s_re      = r_s_re;
    assign bus.s_wdata   = r_s_wdata;

endmodule
`default_nettype wire
